// File: rtl/bit_mixer_pipe.sv
// bit_mixer_pipe: W-bit two-operand bit mixer behind a STAGES-deep elastic pipeline.
// Optional even-parity sideband when BIT_MIXER_PARITY_EN is defined.
module bit_mixer_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     C,
  output logic [CNT_W-1:0] word_cnt
`ifdef BIT_MIXER_PARITY_EN
  ,
  output logic             out_par
`endif
);

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    ZIP_LO = 2'd1,
    ZIP_HI = 2'd2,
    REVX   = 2'd3
  } mode_e;

`ifdef BIT_MIXER_PARITY_EN
  localparam int DW = W + 1;
`else
  localparam int DW = W;
`endif

  logic [W-1:0]      mix_c;
  logic [DW-1:0]     ent_c;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [DW-1:0]     dat_q [STAGES];
  logic [DW-1:0]     dat_d [STAGES];
  logic [STAGES-1:0] load_c;
  logic [STAGES-1:0] src_v_c;
  logic [DW-1:0]     src_d_c [STAGES];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  always_comb begin
    mix_c = A;
    unique case (mode_e'(mode))
      PASS: mix_c = A;
      ZIP_LO: begin
        for (int i = 0; i < W/2; i++) begin
          mix_c[2*i+1] = A[i];
          mix_c[2*i]   = B[i];
        end
      end
      ZIP_HI: begin
        for (int i = 0; i < W/2; i++) begin
          mix_c[2*i+1] = A[W/2+i];
          mix_c[2*i]   = B[W/2+i];
        end
      end
      REVX: begin
        for (int i = 0; i < W; i++) begin
          mix_c[i] = A[W-1-i] ^ B[i];
        end
      end
      default: mix_c = A;
    endcase
  end

`ifdef BIT_MIXER_PARITY_EN
  assign ent_c   = {^mix_c, mix_c};
  assign out_par = dat_q[STAGES-1][W];
`else
  assign ent_c = mix_c;
`endif

  // A stage may load when empty or when its own word moves on this cycle.
  always_comb begin
    load_c = '0;
    load_c[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int k = STAGES-2; k >= 0; k--) begin
      load_c[k] = !v_q[k] || load_c[k+1];
    end
  end

  always_comb begin
    src_v_c    = '0;
    src_v_c[0] = in_valid;
    src_d_c[0] = ent_c;
    for (int k = 1; k < STAGES; k++) begin
      src_v_c[k] = v_q[k-1];
      src_d_c[k] = dat_q[k-1];
    end
  end

  // Data only loads alongside a valid word so C holds while empty.
  always_comb begin
    v_d = v_q;
    for (int k = 0; k < STAGES; k++) begin
      dat_d[k] = dat_q[k];
      if (load_c[k]) begin
        v_d[k] = src_v_c[k];
        if (src_v_c[k]) dat_d[k] = src_d_c[k];
      end
    end
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) dat_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < STAGES; k++) dat_q[k] <= dat_d[k];
    end
  end

  assign in_ready  = load_c[0];
  assign out_valid = v_q[STAGES-1];
  assign C         = dat_q[STAGES-1][W-1:0];
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_bit_mixer_pipe.sv
// tb_bit_mixer_pipe: directed checks of bit_mixer_pipe (W=8, STAGES=2, CNT_W=4).
// Covers reset, modes, streaming, backpressure, counter wrap and optional parity.
module tb_bit_mixer_pipe;

  localparam int W  = 8;
  localparam int ST = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  C;
  logic [CW-1:0] word_cnt;
`ifdef BIT_MIXER_PARITY_EN
  logic          out_par;
`endif

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] mexp [4];

  always #5 clk = ~clk;

  bit_mixer_pipe #(.W(W), .STAGES(ST), .CNT_W(CW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .word_cnt  (word_cnt)
`ifdef BIT_MIXER_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic [1:0] m);
    in_valid = v;
    A        = a;
    B        = b;
    mode     = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    mexp[0] = 8'hA5;
    mexp[1] = 8'h72;
    mexp[2] = 8'h8D;
    mexp[3] = 8'h99;
    rst_n     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_c", 32'(C), 32'h00);
    chk("rst_ir", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // one word per mode, latency check
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      drive(1'b1, 8'hA5, 8'h3C, 2'(m));
      #1 chk($sformatf("m%0d_ir", m), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("m%0d_lat", m), 32'(out_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("m%0d_ov", m), 32'(out_valid), 32'd1);
      chk($sformatf("m%0d_c", m), 32'(C), 32'(mexp[m]));
`ifdef BIT_MIXER_PARITY_EN
      chk($sformatf("m%0d_par", m), 32'(out_par), 32'd0);
`endif
    end

    // streaming
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("st%0d_ov", i), 32'(out_valid), 32'd1);
        chk($sformatf("st%0d_c", i), 32'(C), 32'(mexp[i-2]));
      end
      if (i < 4) begin
        drive(1'b1, 8'hA5, 8'h3C, 2'(i));
        #1 chk($sformatf("st%0d_ir", i), 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("st_cnt", 32'(word_cnt), 32'd4);
    chk("st_empty", 32'(out_valid), 32'd0);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 8'h11, 8'h00, 2'd0);
    #1 chk("bp_ir0", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 8'h22, 8'h00, 2'd0);
    #1 chk("bp_ir1", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 8'h33, 8'h00, 2'd0);
    #1 chk("bp_full", 32'(in_ready), 32'd0);
    chk("bp_ov", 32'(out_valid), 32'd1);
    chk("bp_c0", 32'(C), 32'h11);
    @(negedge clk);
    chk("bp_hold_ir", 32'(in_ready), 32'd0);
    chk("bp_hold_c", 32'(C), 32'h11);
    out_ready = 1'b1;
    #1 chk("bp_pass", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_c1", 32'(C), 32'h22);
    @(negedge clk);
    chk("bp_c2", 32'(C), 32'h33);
    @(negedge clk);
    chk("bp_drain", 32'(out_valid), 32'd0);
    chk("bp_cnt", 32'(word_cnt), 32'd3);

    // asynchronous reset with two words in flight
    out_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 8'hAA, 8'h00, 2'd0);
    @(negedge clk);
    drive(1'b1, 8'hBB, 8'h00, 2'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ov", 32'(out_valid), 32'd0);
    chk("ar_cnt", 32'(word_cnt), 32'd0);
    chk("ar_c", 32'(C), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ar_ir", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("ar_gone%0d", i), 32'(out_valid), 32'd0);
    end

    // counter wrap
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 17) chk("wr_15", 32'(word_cnt), 32'd15);
      if (n == 18) chk("wr_0", 32'(word_cnt), 32'd0);
      if (n == 19) chk("wr_1", 32'(word_cnt), 32'd1);
      drive(n < 17, 8'(n), 8'h00, 2'd0);
    end
    in_valid = 1'b0;

`ifdef BIT_MIXER_PARITY_EN
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 8'hA5, 8'h3C, 2'd1);
    @(negedge clk);
    drive(1'b1, 8'hA5, 8'h3C, 2'd3);
    @(negedge clk);
    drive(1'b1, 8'h01, 8'h00, 2'd0);
    chk("p1_c", 32'(C), 32'h72);
    chk("p1_par", 32'(out_par), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("p3_c", 32'(C), 32'h99);
    chk("p3_par", 32'(out_par), 32'd0);
    @(negedge clk);
    chk("p0_c", 32'(C), 32'h01);
    chk("p0_par", 32'(out_par), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
